sd_init_ctrl: RTL and testbench
===============================

Name: sd_init_ctrl

Overview:
- Sequences the SPI-mode SD card initialisation: power-up dummy clocks, CMD0, CMD8, then the repeated CMD55/ACMD41 loop.
- Serialises each 48-bit command frame onto the card DI line and drives the command index to the SD response receiver.
- Re-arms the receiver before every command, qualifies each response, and reports done or error to the host-side logic.
- Runs in the SPI clock domain, on the same clk as the response receiver.

Parameters:
- POWERUP_CYCLES, 80, dummy clocks with cs_n=1 and di=1 before CMD0.
- RSP_TIMEOUT, 1023, clocks allowed from the last frame bit to the receiver's rsp_valid before a timeout error.
- ACMD41_RETRIES, 255, maximum number of CMD55/ACMD41 pairs that may return R1=0x01.
- GAP_CYCLES, 8, idle clocks (di=1) after each accepted response before the next frame.

Ports:
- clk  in  1  SPI clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- start  in  1  single-cycle request; honoured only in IDLE, DONE or ERR.
- cs_n  out  1  card chip select, active low.
- di  out  1  serial command bit to the card, MSB first, one bit per clk.
- cmd_out  out  6  command index presented to the response receiver.
- rx_reset  out  1  one-cycle re-arm pulse to the response receiver.
- rsp_valid  in  1  receiver "new response" flag; level, sticky until rx_reset.
- rsp  in  40  receiver response word.
- busy  out  1  sequence in progress.
- done  out  1  card initialised; level, held until the next start.
- error  out  1  sequence failed; level, held until the next start.
- err_code  out  3  0 none, 1 timeout, 2 CMD0 R1≠0x01, 3 CMD8 bad echo or R1, 4 ACMD41 retries exhausted, 5 unexpected R1.
- v2_card  out  1  set when CMD8 was accepted with a valid echo.

Behaviour:
- Reset values: cs_n=1, di=1, cmd_out=0, rx_reset=0, busy=0, done=0, error=0, err_code=0, v2_card=0, state=IDLE. Reset mid-frame aborts immediately; no partial frame completes.
- States:
  - IDLE: on start, go to POWERUP; busy=1; clear done, error, err_code and v2_card.
  - POWERUP: cs_n=1, di=1 for exactly POWERUP_CYCLES clocks, then go to LOAD.
  - LOAD: one cycle. Latch cmd_out, assert rx_reset=1 and cs_n=0, load the 48-bit frame into the shift register.
  - SEND: 48 clocks, di = frame bit 47 first. Frame = 2'b01, 6-bit index, 32-bit argument, 7-bit CRC, stop bit 1.
  - WAIT_RSP: di=1. A 0→1 transition of rsp_valid moves to CHECK. If the timeout counter reaches RSP_TIMEOUT, go to ERR with code 1.
  - CHECK: one cycle; evaluate the response rules below.
  - GAP: cs_n=0, di=1 for GAP_CYCLES clocks, then go to LOAD with the next command.
  - DONE: cs_n=1, busy=0, done=1.
  - ERR: cs_n=1, busy=0, error=1, err_code held.
- Command constants:
  - CMD0: argument 0, CRC byte 0x95.
  - CMD8: argument 0x000001AA, CRC byte 0x87.
  - CMD55: argument 0, CRC byte 0xFF.
  - ACMD41 (index 41): argument 0x40000000 if v2_card, else 0; CRC byte 0xFF.
- R1 location: rsp[38:32] for CMD8, rsp[6:0] for all other commands. CMD8 echo is rsp[11:0].
- Response rules:
  - CMD0: R1 must be 0x01, else ERR code 2.
  - CMD8, R1=0x01 with echo 0x1AA: set v2_card=1 and continue.
  - CMD8, R1=0x05 (illegal command, v1 card): continue with v2_card=0.
  - CMD8, any other R1 or echo: ERR code 3.
  - CMD55: R1 must be 0x01 or 0x00, else ERR code 5.
  - ACMD41, R1=0x00: go to DONE after GAP.
  - ACMD41, R1=0x01: increment the retry count. If the count equals ACMD41_RETRIES, ERR code 4; else issue CMD55 again.
  - ACMD41, anything else: ERR code 5.
- Boundary rules:
  - rsp_valid already high on entry to WAIT_RSP cannot occur, because rx_reset cleared it in LOAD. It is still ignored until a fresh rising edge.
  - start while busy is ignored.
  - start in DONE or ERR restarts from POWERUP.
- Counter widths: sized by $clog2 of each parameter plus 1. Counters never wrap; they saturate at their limit.

Decomposition:
- Package sd_pkg holds:
  - command indices CMD0=0, CMD8=8, CMD55=55, ACMD41=41;
  - CRC bytes;
  - CMD8 and ACMD41 argument constants;
  - err_code enumeration;
  - state enumeration.
- One natural sub-module, sd_cmd_shifter: 48-bit load/shift register with a bit counter and a last-bit flag. The FSM stays in sd_init_ctrl.

Test Plan:
- Card model that accepts all commands (CMD0→0x01, CMD8→0x01 with echo 0x1AA, CMD55→0x01, ACMD41→0x01 twice then 0x00) → done=1, v2_card=1, err_code=0. Check 80 clocks precede the CMD0 frame and the CMD0 frame is 0x400000000095.
- CMD8 answered with R1=0x05 → v2_card=0 and the ACMD41 frame argument is 0x00000000; done=1.
- No response to CMD0 (DO held 1) → error=1, err_code=1 after RSP_TIMEOUT+1 clocks in WAIT_RSP; cs_n=1.
- ACMD41 always returns 0x01 with ACMD41_RETRIES=3 → exactly 3 CMD55/ACMD41 pairs sent, then err_code=4.
- CMD8 echo 0x0AA → err_code=3.
- Reset asserted mid-SEND → next cycle cs_n=1, di=1, busy=0. A subsequent start replays POWERUP from scratch.

Source files
------------

// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - shared constants, enums and frame builder for the SD SPI init sequencer
package sd_pkg;

    localparam logic [5:0]  CMD0   = 6'd0;
    localparam logic [5:0]  CMD8   = 6'd8;
    localparam logic [5:0]  CMD55  = 6'd55;
    localparam logic [5:0]  ACMD41 = 6'd41;

    // CRC bytes include the trailing stop bit
    localparam logic [7:0]  CRC_CMD0 = 8'h95;
    localparam logic [7:0]  CRC_CMD8 = 8'h87;
    localparam logic [7:0]  CRC_NONE = 8'hFF;

    localparam logic [31:0] CMD8_ARG       = 32'h0000_01AA;
    localparam logic [31:0] ACMD41_ARG_HCS = 32'h4000_0000;
    localparam logic [11:0] CMD8_ECHO      = 12'h1AA;

    localparam logic [6:0]  R1_READY = 7'h00;
    localparam logic [6:0]  R1_IDLE  = 7'h01;
    localparam logic [6:0]  R1_ILLEGAL_IDLE = 7'h05;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_TIMEOUT = 3'd1,
        ERR_CMD0    = 3'd2,
        ERR_CMD8    = 3'd3,
        ERR_RETRY   = 3'd4,
        ERR_R1      = 3'd5
    } err_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_POWERUP,
        ST_LOAD,
        ST_SEND,
        ST_WAIT_RSP,
        ST_CHECK,
        ST_GAP,
        ST_DONE,
        ST_ERR
    } state_t;

    // Assemble the 48-bit command frame: start 01, index, argument, CRC+stop
    function automatic logic [47:0] build_frame(input logic [5:0] idx, input logic v2);
        logic [31:0] arg;
        logic [7:0]  crc;
        arg = 32'h0;
        crc = CRC_NONE;
        case (idx)
            CMD0:    crc = CRC_CMD0;
            CMD8:    begin
                arg = CMD8_ARG;
                crc = CRC_CMD8;
            end
            ACMD41:  arg = v2 ? ACMD41_ARG_HCS : 32'h0;
            default: ;
        endcase
        return {2'b01, idx, arg, crc};
    endfunction

endpackage

// File: rtl/sd_cmd_shifter.sv
// rtl/sd_cmd_shifter.sv - 48-bit command frame shift register, MSB first
module sd_cmd_shifter (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        shift,
    input  logic [47:0] frame,
    output logic        sdo,
    output logic        last
);

    logic [47:0] sreg;
    logic [5:0]  bit_cnt;
    logic        active;

    // Shift in ones so the line idles high once the frame has left
    always_ff @(posedge clk) begin
        if (reset) begin
            sreg    <= '1;
            bit_cnt <= 6'd0;
            active  <= 1'b0;
        end else if (load) begin
            sreg    <= frame;
            bit_cnt <= 6'd0;
            active  <= 1'b1;
        end else if (shift && active) begin
            sreg <= {sreg[46:0], 1'b1};
            if (bit_cnt == 6'd47) begin
                active <= 1'b0;
            end else begin
                bit_cnt <= bit_cnt + 6'd1;
            end
        end
    end

    assign sdo  = sreg[47];
    assign last = active && (bit_cnt == 6'd47);

endmodule

// File: rtl/sd_init_ctrl.sv
// rtl/sd_init_ctrl.sv - SPI-mode SD card initialisation sequencer (CMD0, CMD8, CMD55/ACMD41)
module sd_init_ctrl #(
    parameter int POWERUP_CYCLES = 80,
    parameter int RSP_TIMEOUT    = 1023,
    parameter int ACMD41_RETRIES = 255,
    parameter int GAP_CYCLES     = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        cs_n,
    output logic        di,
    output logic [5:0]  cmd_out,
    output logic        rx_reset,
    input  logic        rsp_valid,
    input  logic [39:0] rsp,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [2:0]  err_code,
    output logic        v2_card
);

    import sd_pkg::*;

    localparam int PW = $clog2(POWERUP_CYCLES) + 1;
    localparam int TW = $clog2(RSP_TIMEOUT) + 1;
    localparam int GW = $clog2(GAP_CYCLES) + 1;
    localparam int RW = $clog2(ACMD41_RETRIES) + 1;

    localparam logic [PW-1:0] PU_LAST    = PW'(POWERUP_CYCLES - 1);
    localparam logic [TW-1:0] TO_LIMIT   = TW'(RSP_TIMEOUT);
    localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_LAST = RW'(ACMD41_RETRIES - 1);

    state_t        state;
    logic [PW-1:0] pu_cnt;
    logic [TW-1:0] to_cnt;
    logic [GW-1:0] gap_cnt;
    logic [RW-1:0] retry_cnt;
    logic          rsp_valid_q;
    logic [6:0]    r1_lo;
    logic [6:0]    r1_hi;
    logic [11:0]   echo;
    logic [5:0]    next_cmd;
    logic          finish;

    logic          sh_last;
    logic          rsp_unused;

    err_t          chk_err;
    logic [5:0]    chk_next;
    logic          chk_finish;
    logic          chk_v2;
    logic          chk_retry;

    // Only the R1 fields and the CMD8 echo matter to the sequencer
    assign rsp_unused = ^{rsp[39], rsp[31:12]};

    sd_cmd_shifter u_shifter (
        .clk   (clk),
        .reset (reset),
        .load  (state == ST_LOAD),
        .shift (state == ST_SEND),
        .frame (build_frame(cmd_out, v2_card)),
        .sdo   (di),
        .last  (sh_last)
    );

    // Qualify the captured response for the command that was just sent
    always_comb begin
        chk_err    = ERR_NONE;
        chk_next   = next_cmd;
        chk_finish = 1'b0;
        chk_v2     = v2_card;
        chk_retry  = 1'b0;
        case (cmd_out)
            CMD0: begin
                if (r1_lo == R1_IDLE) chk_next = CMD8;
                else                  chk_err  = ERR_CMD0;
            end
            CMD8: begin
                if (r1_hi == R1_IDLE && echo == CMD8_ECHO) begin
                    chk_v2   = 1'b1;
                    chk_next = CMD55;
                end else if (r1_hi == R1_ILLEGAL_IDLE) begin
                    chk_next = CMD55;
                end else begin
                    chk_err = ERR_CMD8;
                end
            end
            CMD55: begin
                if (r1_lo == R1_IDLE || r1_lo == R1_READY) chk_next = ACMD41;
                else                                       chk_err  = ERR_R1;
            end
            ACMD41: begin
                if (r1_lo == R1_READY) begin
                    chk_finish = 1'b1;
                end else if (r1_lo == R1_IDLE) begin
                    if (retry_cnt == RETRY_LAST) begin
                        chk_err = ERR_RETRY;
                    end else begin
                        chk_retry = 1'b1;
                        chk_next  = CMD55;
                    end
                end else begin
                    chk_err = ERR_R1;
                end
            end
            default: chk_err = ERR_R1;
        endcase
    end

    // Sequencer FSM with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            pu_cnt      <= '0;
            to_cnt      <= '0;
            gap_cnt     <= '0;
            retry_cnt   <= '0;
            rsp_valid_q <= 1'b0;
            r1_lo       <= 7'h0;
            r1_hi       <= 7'h0;
            echo        <= 12'h0;
            next_cmd    <= CMD0;
            finish      <= 1'b0;
            cs_n        <= 1'b1;
            cmd_out     <= 6'd0;
            rx_reset    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            err_code    <= ERR_NONE;
            v2_card     <= 1'b0;
        end else begin
            rx_reset    <= 1'b0;
            rsp_valid_q <= rsp_valid;
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        state     <= ST_POWERUP;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        error     <= 1'b0;
                        err_code  <= ERR_NONE;
                        v2_card   <= 1'b0;
                        cs_n      <= 1'b1;
                        pu_cnt    <= '0;
                        retry_cnt <= '0;
                    end
                end
                ST_POWERUP: begin
                    if (pu_cnt == PU_LAST) begin
                        state    <= ST_LOAD;
                        cmd_out  <= CMD0;
                        rx_reset <= 1'b1;
                        cs_n     <= 1'b0;
                    end else begin
                        pu_cnt <= pu_cnt + PW'(1);
                    end
                end
                ST_LOAD: state <= ST_SEND;
                ST_SEND: begin
                    if (sh_last) begin
                        state  <= ST_WAIT_RSP;
                        to_cnt <= '0;
                    end
                end
                ST_WAIT_RSP: begin
                    if (rsp_valid && !rsp_valid_q) begin
                        state <= ST_CHECK;
                        r1_lo <= rsp[6:0];
                        r1_hi <= rsp[38:32];
                        echo  <= rsp[11:0];
                    end else if (to_cnt == TO_LIMIT) begin
                        state    <= ST_ERR;
                        busy     <= 1'b0;
                        error    <= 1'b1;
                        err_code <= ERR_TIMEOUT;
                        cs_n     <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                ST_CHECK: begin
                    if (chk_err != ERR_NONE) begin
                        state    <= ST_ERR;
                        busy     <= 1'b0;
                        error    <= 1'b1;
                        err_code <= chk_err;
                        cs_n     <= 1'b1;
                    end else begin
                        state    <= ST_GAP;
                        gap_cnt  <= '0;
                        next_cmd <= chk_next;
                        finish   <= chk_finish;
                        v2_card  <= chk_v2;
                        if (chk_retry) retry_cnt <= retry_cnt + RW'(1);
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        if (finish) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            cs_n  <= 1'b1;
                        end else begin
                            state    <= ST_LOAD;
                            cmd_out  <= next_cmd;
                            rx_reset <= 1'b1;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_init_ctrl.sv
// tb/tb_sd_init_ctrl.sv - randomized self-checking bench for sd_init_ctrl with an SD card model
module tb_sd_init_ctrl;

    localparam int PU = 80;
    localparam int TO = 1023;
    localparam int RETRIES = 3;
    localparam int GAP = 8;
    localparam int BUDGET = 20000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        cs_n, di, rx_reset, busy, done, error, v2_card;
    logic [5:0]  cmd_out;
    logic [2:0]  err_code;
    logic        rsp_valid = 1'b0;
    logic [39:0] rsp = 40'h0;

    int checks = 0;
    int errors = 0;

    // card behaviour for the current run
    bit         cfg_silent;
    logic [6:0] cfg_cmd0_r1, cfg_cmd8_r1, cfg_cmd55_r1, cfg_acmd_final;
    logic [11:0] cfg_cmd8_echo;
    int         cfg_acmd_ones;

    // monitor state
    logic [47:0] frames[$];
    logic [47:0] sh;
    logic [5:0]  cur_idx;
    int  nbits, delay, wait_cnt, waited, pu_count, rx_pulses, acmd_seen;
    bit  in_frame, pending, timing, seen_cs_low;

    // reference expectations
    int  exp_cmds[$];
    bit  exp_done, exp_v2;
    int  exp_err;

    sd_init_ctrl #(
        .POWERUP_CYCLES (PU),
        .RSP_TIMEOUT    (TO),
        .ACMD41_RETRIES (RETRIES),
        .GAP_CYCLES     (GAP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .cs_n      (cs_n),
        .di        (di),
        .cmd_out   (cmd_out),
        .rx_reset  (rx_reset),
        .rsp_valid (rsp_valid),
        .rsp       (rsp),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .err_code  (err_code),
        .v2_card   (v2_card)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [47:0] exp_frame(input int idx, input bit v2);
        logic [31:0] arg;
        logic [7:0]  crc;
        arg = 32'h0;
        crc = 8'hFF;
        if (idx == 0) crc = 8'h95;
        if (idx == 8) begin
            arg = 32'h1AA;
            crc = 8'h87;
        end
        if (idx == 41 && v2) arg = 32'h4000_0000;
        return {2'b01, 6'(idx), arg, crc};
    endfunction

    // Walk the initialisation protocol against the configured card answers
    function automatic void model_run();
        logic [6:0] r1;
        exp_cmds.delete();
        exp_done = 0;
        exp_err  = 0;
        exp_v2   = 0;
        exp_cmds.push_back(0);
        if (cfg_silent) begin exp_err = 1; return; end
        if (cfg_cmd0_r1 != 7'h01) begin exp_err = 2; return; end
        exp_cmds.push_back(8);
        if (cfg_cmd8_r1 == 7'h01 && cfg_cmd8_echo == 12'h1AA) exp_v2 = 1;
        else if (cfg_cmd8_r1 != 7'h05) begin exp_err = 3; return; end
        for (int n = 0; n < RETRIES; n++) begin
            exp_cmds.push_back(55);
            if (cfg_cmd55_r1 > 7'h01) begin exp_err = 5; return; end
            exp_cmds.push_back(41);
            r1 = (n < cfg_acmd_ones) ? 7'h01 : cfg_acmd_final;
            if (r1 == 7'h00) begin exp_done = 1; return; end
            if (r1 != 7'h01) begin exp_err = 5; return; end
            if (n + 1 == RETRIES) begin exp_err = 4; return; end
        end
    endfunction

    task automatic respond(input logic [5:0] idx);
        logic [63:0] rnd;
        rnd = {$urandom(), $urandom()};
        rsp = rnd[39:0];
        case (idx)
            6'd0: begin
                if (cfg_silent) return;
                rsp[6:0] = cfg_cmd0_r1;
            end
            6'd8: begin
                rsp[38:32] = cfg_cmd8_r1;
                rsp[11:0]  = cfg_cmd8_echo;
            end
            6'd55: rsp[6:0] = cfg_cmd55_r1;
            6'd41: begin
                rsp[6:0] = (acmd_seen < cfg_acmd_ones) ? 7'h01 : cfg_acmd_final;
                acmd_seen++;
            end
            default: ;
        endcase
        rsp_valid = 1'b1;
    endtask

    // Card side: decode frames from cs_n/di, answer after a random delay
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                in_frame  = 0;
                pending   = 0;
                timing    = 0;
                rsp_valid = 1'b0;
            end else begin
                if (rx_reset) begin
                    rsp_valid = 1'b0;
                    rx_pulses++;
                end
                if (busy && cs_n && !seen_cs_low) pu_count++;
                if (!cs_n) seen_cs_low = 1;
                if (timing) begin
                    if (error) begin
                        waited = wait_cnt;
                        timing = 0;
                    end else if (rsp_valid) begin
                        timing = 0;
                    end else begin
                        wait_cnt++;
                    end
                end
                if (pending) begin
                    if (delay > 0) delay--;
                    else begin
                        pending = 0;
                        respond(cur_idx);
                    end
                end
                if (in_frame) begin
                    sh = {sh[46:0], di};
                    nbits++;
                    if (nbits == 48) begin
                        in_frame = 0;
                        frames.push_back(sh);
                        cur_idx  = sh[45:40];
                        pending  = 1;
                        delay    = $urandom_range(0, 29);
                        timing   = 1;
                        wait_cnt = 0;
                    end
                end else if (!cs_n && !di) begin
                    in_frame = 1;
                    sh       = 48'h0;
                    nbits    = 1;
                end
            end
        end
    end

    task automatic set_cfg(input bit silent, input logic [6:0] c0, input logic [6:0] c8,
                           input logic [11:0] ech, input logic [6:0] c55, input int ones,
                           input logic [6:0] fin);
        cfg_silent     = silent;
        cfg_cmd0_r1    = c0;
        cfg_cmd8_r1    = c8;
        cfg_cmd8_echo  = ech;
        cfg_cmd55_r1   = c55;
        cfg_acmd_ones  = ones;
        cfg_acmd_final = fin;
    endtask

    task automatic clear_run();
        frames.delete();
        pu_count    = 0;
        seen_cs_low = 0;
        rx_pulses   = 0;
        acmd_seen   = 0;
        waited      = -1;
    endtask

    task automatic run_case(input string tag, input int restart_at, input bit chk_time);
        int cyc;
        model_run();
        clear_run();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!(done || error) && cyc < BUDGET) begin
            start = (cyc == restart_at);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({tag, " finished"}, cyc < BUDGET, 1);
        check({tag, " done"}, done, exp_done);
        check({tag, " error"}, error, exp_err != 0);
        check({tag, " err_code"}, err_code, exp_err);
        check({tag, " v2_card"}, v2_card, exp_v2);
        check({tag, " busy"}, busy, 0);
        check({tag, " cs_n"}, cs_n, 1);
        check({tag, " powerup clocks"}, pu_count, PU);
        check({tag, " frame count"}, frames.size(), exp_cmds.size());
        check({tag, " rx_reset pulses"}, rx_pulses, exp_cmds.size());
        for (int i = 0; i < frames.size() && i < exp_cmds.size(); i++)
            check($sformatf("%s frame%0d", tag, i), frames[i], exp_frame(exp_cmds[i], exp_v2));
        if (chk_time) check({tag, " timeout clocks"}, waited, TO + 1);
    endtask

    initial begin
        int  cyc, k;
        bit  seen41;
        repeat (3) @(negedge clk);
        check("reset cs_n", cs_n, 1);
        check("reset di", di, 1);
        check("reset cmd_out", cmd_out, 0);
        check("reset rx_reset", rx_reset, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset error", error, 0);
        check("reset err_code", err_code, 0);
        check("reset v2_card", v2_card, 0);
        reset = 1'b0;

        set_cfg(0, 7'h01, 7'h01, 12'h1AA, 7'h01, 2, 7'h00);
        run_case("accept", 40, 0);
        check("cmd0 frame", frames.size() > 0 ? frames[0] : 48'h0, 48'h4000_0000_0095);

        set_cfg(0, 7'h01, 7'h05, 12'($urandom()), 7'h00, 1, 7'h00);
        run_case("v1card", 200, 0);
        seen41 = 0;
        foreach (frames[i]) begin
            if (!seen41 && frames[i][45:40] == 6'd41) begin
                check("v1 acmd41 arg", frames[i][39:8], 32'h0);
                seen41 = 1;
            end
        end
        check("v1 acmd41 seen", seen41, 1);

        set_cfg(1, 7'h01, 7'h01, 12'h1AA, 7'h01, 0, 7'h00);
        run_case("silent", 500, 1);

        set_cfg(0, 7'h01, 7'h01, 12'h1AA, 7'h01, 99, 7'h00);
        run_case("retries", -1, 0);

        set_cfg(0, 7'h01, 7'h01, 12'h0AA, 7'h01, 0, 7'h00);
        run_case("bad echo", -1, 0);

        set_cfg(0, 7'h01, 7'h01, 12'h1AA, 7'h01, 2, 7'h00);
        clear_run();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = $urandom_range(5, 40);
        cyc = 0;
        while (!(in_frame && nbits >= k) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check("rst reached send", cyc < 2000, 1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst cs_n", cs_n, 1);
        check("rst di", di, 1);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst error", error, 0);
        reset = 1'b0;
        run_case("post reset", -1, 0);

        for (int it = 0; it < 10; it++) begin
            logic [6:0] c0, c8, c55, fin;
            logic [11:0] ech;
            bit sil;
            int sel;
            sil = ($urandom_range(0, 9) == 0);
            c0  = ($urandom_range(0, 4) == 0) ? 7'($urandom_range(0, 127)) : 7'h01;
            sel = $urandom_range(0, 3);
            case (sel)
                0:       begin c8 = 7'h01; ech = 12'h1AA; end
                1:       begin c8 = 7'h05; ech = 12'($urandom()); end
                2:       begin c8 = 7'h01; ech = 12'($urandom()); end
                default: begin c8 = 7'($urandom_range(0, 127)); ech = 12'h1AA; end
            endcase
            c55 = ($urandom_range(0, 5) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 1));
            fin = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'h00;
            set_cfg(sil, c0, c8, ech, c55, $urandom_range(0, 4), fin);
            run_case($sformatf("rand%0d", it), $urandom_range(5, 300), sil);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
